// File: rtl/reg_response_serializer.sv
// reg_response_serializer
// Turns one-cycle register read responses into a framed word stream:
// address, REG_WIDTH data words, XOR checksum. Responses that arrive
// while a frame cannot take them are discarded and counted.
module reg_response_serializer #(
  parameter int WORD_WIDTH    = 8,
  parameter int REG_WIDTH     = 4,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic                            clk,
  input  logic                            i_reset,
  input  logic                            i_r_valid,
  input  logic [WORD_WIDTH-1:0]           i_r_addr,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0] i_r_value,
  output logic [WORD_WIDTH-1:0]           o_tx_data,
  output logic                            o_tx_valid,
  input  logic                            i_tx_ready,
  output logic                            o_busy,
  output logic                            o_drop,
  output logic [7:0]                      o_drop_count
);

  localparam int VAL_W = WORD_WIDTH * REG_WIDTH;
  localparam int IDX_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  // XOR of the address and every data word of the response.
  function automatic logic [WORD_WIDTH-1:0] calc_csum(
    input logic [WORD_WIDTH-1:0] addr,
    input logic [VAL_W-1:0]      value
  );
    logic [WORD_WIDTH-1:0] acc;
    acc = addr;
    for (int k = 0; k < REG_WIDTH; k++) begin
      acc = acc ^ value[k*WORD_WIDTH +: WORD_WIDTH];
    end
    return acc;
  endfunction

  // Next data word to send: the captured value is consumed from the end
  // selected by LITTLE_ENDIAN, so no variable word index is needed.
  function automatic logic [WORD_WIDTH-1:0] head_word(input logic [VAL_W-1:0] value);
    if (LITTLE_ENDIAN != 0) begin
      return value[WORD_WIDTH-1:0];
    end else begin
      return value[VAL_W-1 -: WORD_WIDTH];
    end
  endfunction

  // Drop the word just sent from the captured value.
  function automatic logic [VAL_W-1:0] shift_out(input logic [VAL_W-1:0] value);
    if (LITTLE_ENDIAN != 0) begin
      return value >> WORD_WIDTH;
    end else begin
      return value << WORD_WIDTH;
    end
  endfunction

  state_t                 state_q, state_d;
  logic [VAL_W-1:0]       data_q, data_d;
  logic [WORD_WIDTH-1:0]  csum_q, csum_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   drop_q, drop_d;
  logic [7:0]             drop_count_q, drop_count_d;
  logic                   hs_s;
  logic                   accept_s;

  // Next-state, next-word and drop bookkeeping for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    csum_d       = csum_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    hs_s         = tx_valid_q && i_tx_ready;
    accept_s     = i_r_valid && ((state_q == ST_IDLE) || ((state_q == ST_CSUM) && hs_s));
    drop_d       = i_r_valid && !accept_s;
    drop_count_d = drop_count_q;

    if (drop_d && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end

    if (accept_s) begin
      // New response: the address goes out next cycle, also straight from CSUM.
      state_d    = ST_ADDR;
      data_d     = i_r_value;
      csum_d     = calc_csum(i_r_addr, i_r_value);
      idx_d      = '0;
      tx_data_d  = i_r_addr;
      tx_valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
        end
        ST_ADDR: begin
          if (hs_s) begin
            state_d   = ST_DATA;
            idx_d     = '0;
            tx_data_d = head_word(data_q);
            data_d    = shift_out(data_q);
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (hs_s) begin
            if (idx_q == LAST_IDX) begin
              state_d   = ST_CSUM;
              idx_d     = '0;
              tx_data_d = csum_q;
            end else begin
              idx_d     = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
              tx_data_d = head_word(data_q);
              data_d    = shift_out(data_q);
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_CSUM: begin
          if (hs_s) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
          end else begin
            state_d = ST_CSUM;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          idx_d      = '0;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      csum_q       <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      drop_q       <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      csum_q       <= csum_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_drop       = drop_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_reg_response_serializer.sv
// Directed bench for reg_response_serializer: one big-endian and one
// little-endian instance driven with identical stimulus.
module tb_reg_response_serializer;

  logic        clk;
  logic        i_reset;
  logic        i_r_valid;
  logic [7:0]  i_r_addr;
  logic [31:0] i_r_value;
  logic        i_tx_ready;

  logic [7:0]  be_data, le_data;
  logic        be_valid, le_valid;
  logic        be_busy, le_busy;
  logic        be_drop, le_drop;
  logic [7:0]  be_cnt, le_cnt;

  int n_vec;
  int n_mis;

  logic [7:0] e_be [6];
  logic [7:0] e_le [6];

  reg_response_serializer #(.WORD_WIDTH(8), .REG_WIDTH(4), .LITTLE_ENDIAN(0)) dut_be (
    .clk(clk), .i_reset(i_reset), .i_r_valid(i_r_valid), .i_r_addr(i_r_addr),
    .i_r_value(i_r_value), .o_tx_data(be_data), .o_tx_valid(be_valid),
    .i_tx_ready(i_tx_ready), .o_busy(be_busy), .o_drop(be_drop), .o_drop_count(be_cnt)
  );

  reg_response_serializer #(.WORD_WIDTH(8), .REG_WIDTH(4), .LITTLE_ENDIAN(1)) dut_le (
    .clk(clk), .i_reset(i_reset), .i_r_valid(i_r_valid), .i_r_addr(i_r_addr),
    .i_r_value(i_r_value), .o_tx_data(le_data), .o_tx_valid(le_valid),
    .i_tx_ready(i_tx_ready), .o_busy(le_busy), .o_drop(le_drop), .o_drop_count(le_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both instances must be offering word k of their expected frames.
  task automatic check_word(input string tag, input int k);
    check_val({tag, "_be_valid"}, {31'd0, be_valid}, 32'd1);
    check_val({tag, "_le_valid"}, {31'd0, le_valid}, 32'd1);
    check_val({tag, "_be_data"}, {24'd0, be_data}, {24'd0, e_be[k]});
    check_val({tag, "_le_data"}, {24'd0, le_data}, {24'd0, e_le[k]});
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_be_valid"}, {31'd0, be_valid}, 32'd0);
    check_val({tag, "_le_valid"}, {31'd0, le_valid}, 32'd0);
    check_val({tag, "_be_busy"}, {31'd0, be_busy}, 32'd0);
    check_val({tag, "_le_busy"}, {31'd0, le_busy}, 32'd0);
  endtask

  task automatic check_drop(input string tag, input logic drop, input logic [7:0] cnt);
    check_val({tag, "_be_drop"}, {31'd0, be_drop}, {31'd0, drop});
    check_val({tag, "_le_drop"}, {31'd0, le_drop}, {31'd0, drop});
    check_val({tag, "_be_cnt"}, {24'd0, be_cnt}, {24'd0, cnt});
    check_val({tag, "_le_cnt"}, {24'd0, le_cnt}, {24'd0, cnt});
  endtask

  // Present one response for one cycle; after return the address is on the bus.
  task automatic send_resp(input logic [7:0] addr, input logic [31:0] value);
    i_r_valid = 1'b1;
    i_r_addr  = addr;
    i_r_value = value;
    tick();
    i_r_valid = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_mis      = 0;
    i_reset    = 1'b1;
    i_r_valid  = 1'b0;
    i_r_addr   = 8'h00;
    i_r_value  = 32'h0;
    i_tx_ready = 1'b1;
    e_be = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};
    e_le = '{8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h21};

    tick();
    tick();
    check_idle("reset");
    check_val("reset_be_data", {24'd0, be_data}, 32'd0);
    check_drop("reset", 1'b0, 8'd0);

    // Basic frame, accepted in the first cycle after reset release.
    i_reset = 1'b0;
    send_resp(8'h03, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      check_word($sformatf("basic_w%0d", k), k);
      tick();
    end
    check_idle("basic_end");

    // Backpressure: word index 2 held for three cycles of ready low.
    send_resp(8'h03, 32'hDEADBEEF);
    check_word("bp_w0", 0);
    tick();
    check_word("bp_w1", 1);
    tick();
    check_word("bp_w2", 2);
    i_tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_word($sformatf("bp_hold%0d", c), 2);
    end
    i_tx_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      tick();
      check_word($sformatf("bp_w%0d", k), k);
    end
    tick();
    check_idle("bp_end");

    // Drop while in DATA: frame continues untouched.
    send_resp(8'h03, 32'hDEADBEEF);
    tick();
    check_word("drop_w1", 1);
    send_resp(8'h07, 32'h12345678);
    check_word("drop_w2", 2);
    check_drop("drop_pulse", 1'b1, 8'd1);
    tick();
    check_word("drop_w3", 3);
    check_drop("drop_after", 1'b0, 8'd1);
    tick();
    check_word("drop_w4", 4);
    tick();
    check_word("drop_w5", 5);

    // Saturation: hold the checksum and drop 300 responses.
    i_tx_ready = 1'b0;
    i_r_valid  = 1'b1;
    i_r_addr   = 8'h07;
    for (int c = 0; c < 300; c++) begin
      tick();
    end
    check_drop("sat", 1'b1, 8'd255);
    check_word("sat_hold", 5);
    i_r_valid  = 1'b0;
    i_tx_ready = 1'b1;
    tick();
    check_drop("sat_after", 1'b0, 8'd255);
    tick();
    check_idle("sat_end");

    // Back-to-back: new response accepted on the checksum handshake.
    send_resp(8'h03, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check_word("b2b_csum", 5);
    i_r_valid = 1'b1;
    i_r_addr  = 8'h05;
    i_r_value = 32'h00000001;
    tick();
    i_r_valid = 1'b0;
    e_be = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04};
    e_le = '{8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    check_drop("b2b_nodrop", 1'b0, 8'd255);
    for (int k = 0; k < 6; k++) begin
      check_word($sformatf("b2b_w%0d", k), k);
      tick();
    end
    check_idle("b2b_end");

    // Reset mid-frame, with a response offered during reset.
    send_resp(8'h05, 32'h00000001);
    tick();
    check_word("rst_w1", 1);
    i_reset   = 1'b1;
    i_r_valid = 1'b1;
    tick();
    check_idle("rst_mid");
    check_drop("rst_mid", 1'b0, 8'd0);
    i_reset   = 1'b0;
    i_r_valid = 1'b0;
    tick();
    check_idle("rst_after");
    check_drop("rst_after", 1'b0, 8'd0);
    send_resp(8'h05, 32'h00000001);
    for (int k = 0; k < 6; k++) begin
      check_word($sformatf("rst_new_w%0d", k), k);
      tick();
    end
    check_idle("rst_new_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
